baby_ext_mem_bridge: RTL and testbench
======================================

Name: baby_ext_mem_bridge

Overview:
- Sequencer between the Manchester Baby core's 32-bit memory port and the 8-bit tile I/O.
- Serialises each core request into a header byte followed by four data bytes over an 8-bit valid/ready link. For reads, it collects four bytes back into a 32-bit word.
- Sits directly upstream of the byte-width pack/unpack stages. It owns the beat sequencing and handshake that those stages leave to their controller.

Parameters:
- ADDR_W, 5, word address width (32-word store); must be ≤7.
- TIMEOUT, 255, maximum idle-wait cycles per beat before abort; 0 disables timeout.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_i  in  1  core request, sampled only in IDLE
- we_i  in  1  1 = write, 0 = read; latched with req_i
- addr_i  in  ADDR_W  word address; latched with req_i
- wdata_i  in  32  write data; latched with req_i
- ack_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle pulse coincident with ack_o on timeout
- rdata_o  out  32  last successfully read word; held until next successful read
- busy_o  out  1  high in any state other than IDLE
- ext_data_o  out  8  outgoing byte (header or write data)
- ext_valid_o  out  1  outgoing byte valid
- ext_ready_i  in  1  external side accepts outgoing byte
- ext_data_i  in  8  incoming read byte
- ext_valid_i  in  1  incoming read byte valid (bridge is always ready in RD)

Behaviour:
- Reset (async assert, sync deassert by flop nature):
  - state=IDLE.
  - ack_o=0, err_o=0, busy_o=0.
  - rdata_o=0, ext_data_o=0, ext_valid_o=0.
  - Byte counter=0, timeout counter=0.
  - Reset mid-transfer aborts immediately with no ack. The latched request is discarded.
- States: IDLE, HDR, WR, RD, DONE.
- IDLE:
  - When req_i=1 at a clock edge, latch we_i/addr_i/wdata_i and go to HDR.
  - ext_valid_o=0.
- HDR:
  - ext_valid_o=1.
  - ext_data_o = {we, (7-ADDR_W) zero bits, addr}.
  - Transfer on ext_valid_o & ext_ready_i. Then go to WR if we=1, else RD, with byte counter=0.
- WR:
  - ext_valid_o=1, ext_data_o = wdata byte[counter], least-significant byte first.
  - Each transfer increments the counter.
  - The transfer at counter=3 goes to DONE.
- RD:
  - ext_valid_o=0.
  - Each cycle with ext_valid_i=1 captures ext_data_i into shadow byte[counter], least-significant first, and increments the counter.
  - The capture at counter=3 goes to DONE and copies the full shadow word to rdata_o in the same edge.
- DONE:
  - ack_o=1 for exactly this one cycle, then go to IDLE.
  - req_i is ignored in DONE, so back-to-back requests need req_i still high in the following IDLE cycle.
- Handshake rules:
  - ext_data_o is stable while ext_valid_o=1 and ext_ready_i=0.
  - ext_valid_i is ignored outside RD.
  - ext_ready_i is ignored outside HDR/WR.
  - req_i is ignored while busy_o=1.
- Latency with no stalls:
  - req sampled at edge 0.
  - Header transfers at edge 1.
  - Data beats at edges 2–5.
  - ack_o high in the cycle after edge 5, i.e. 6 cycles request-to-ack for both read and write.
  - Each stall cycle adds exactly one cycle.
- Timeout (TIMEOUT>0):
  - Counter clears on entry to HDR/WR/RD and on every beat transfer/capture.
  - Counter increments on every waiting cycle in HDR/WR/RD.
  - On reaching TIMEOUT, go to DONE with err_o=1 alongside ack_o.
  - rdata_o is unchanged; partially captured bytes are discarded.
- busy_o = (state != IDLE), registered state decode.
- Outputs are driven from registered state. There is no combinational path from ext_ready_i or ext_valid_i to any output.

Test Plan:
- Write, ready tied high: req, we=1, addr=5'h1A, wdata=32'hDEADBEEF → ext_data_o sequence 8'h9A, EF, BE, AD, DE on edges 1–5; ack_o pulse in cycle 6; err_o=0.
- Read, ext_valid_i high presenting 8'h78, 56, 34, 12: req, we=0, addr=5'h03 → header 8'h03; rdata_o=32'h12345678 when ack_o=1.
- Backpressure: write with ext_ready_i low 3 cycles during beat 2 → ext_data_o held at byte 2 throughout; ack at cycle 9; bytes in order, none duplicated.
- Timeout: TIMEOUT=4, read with ext_valid_i never asserted → ack_o=1 and err_o=1 together in the 6th cycle after req; rdata_o keeps its previous value; busy_o=0 next cycle.
- Reset mid-op: assert rst_n=0 during WR beat 1 → all outputs zero immediately (async); after release, a new read completes normally with the correct header.
- Busy ignore and back-to-back: toggle req_i with new addr during WR → no effect on the stream. Then hold req_i high through ack → second transfer header appears exactly 2 cycles after ack (DONE→IDLE→HDR).

Source files
------------

// File: rtl/baby_ext_mem_bridge_if.sv
// Signal bundle between the Baby core memory port, the external-memory bridge and the 8-bit tile link.
// Names follow the bridge's view: _i flows into the bridge, _o flows out of it.
interface baby_ext_mem_bridge_if #(
  parameter int ADDR_W = 5
);
  // Link handshake: a byte moves on a rising edge where its valid and ready are both high.
  // The sender holds data stable while valid is high and ready is low. The bridge is always
  // ready for incoming read bytes while collecting a read, so the incoming side has no ready.
  logic              req_i;
  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       wdata_i;
  logic              ack_o;
  logic              err_o;
  logic [31:0]       rdata_o;
  logic              busy_o;
  logic [7:0]        ext_data_o;
  logic              ext_valid_o;
  logic              ext_ready_i;
  logic [7:0]        ext_data_i;
  logic              ext_valid_i;
  logic [2:0]        dbg_state_o;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, ext_ready_i, ext_data_i, ext_valid_i,
    output ack_o, err_o, rdata_o, busy_o, ext_data_o, ext_valid_o, dbg_state_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, ext_ready_i, ext_data_i, ext_valid_i,
    input  ack_o, err_o, rdata_o, busy_o, ext_data_o, ext_valid_o, dbg_state_o
  );
endinterface

// File: rtl/baby_ext_mem_bridge.sv
// Sequences one 32-bit core access into a header byte plus four data bytes on the 8-bit link,
// and reassembles four incoming bytes into a word for reads. All outputs come from flops.
module baby_ext_mem_bridge #(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  baby_ext_mem_bridge_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_WR   = 3'd2,
    S_RD   = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam int            TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit            TO_EN  = (TIMEOUT > 0);
  localparam logic [TW-1:0] T_LAST = TO_EN ? TW'(TIMEOUT - 1) : '0;

  state_e            state_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [23:0]       shadow_q;
  logic [31:0]       rdata_q;
  logic [1:0]        cnt_q;
  logic [TW-1:0]     tcnt_q;
  logic              ack_q;
  logic              err_q;
  logic              busy_q;
  logic              valid_q;
  logic [7:0]        data_q;

  logic              out_xfer;
  logic              in_cap;
  logic              tmo_hit;
  logic [1:0]        cnt_inc;
  logic [7:0]        hdr_d;
  logic [7:0]        wbyte_d;

  // valid_q is only ever high in HDR/WR, so ext_ready_i has no effect elsewhere.
  assign out_xfer = valid_q & bus.ext_ready_i;
  assign in_cap   = (state_q == S_RD) & bus.ext_valid_i;
  assign tmo_hit  = TO_EN && (tcnt_q == T_LAST);
  assign cnt_inc  = cnt_q + 2'd1;
  assign hdr_d    = {bus.we_i, 7'(bus.addr_i)};

  always_comb begin
    wbyte_d = wdata_q[7:0];
    case (cnt_inc)
      2'd1:    wbyte_d = wdata_q[15:8];
      2'd2:    wbyte_d = wdata_q[23:16];
      2'd3:    wbyte_d = wdata_q[31:24];
      default: wbyte_d = wdata_q[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      shadow_q <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      tcnt_q   <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req_i) begin
            we_q    <= bus.we_i;
            addr_q  <= bus.addr_i;
            wdata_q <= bus.wdata_i;
            state_q <= S_HDR;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
            data_q  <= hdr_d;
            cnt_q   <= '0;
            tcnt_q  <= '0;
          end
        end

        S_HDR: begin
          if (out_xfer) begin
            cnt_q  <= '0;
            tcnt_q <= '0;
            if (we_q) begin
              state_q <= S_WR;
              data_q  <= wdata_q[7:0];
            end else begin
              state_q <= S_RD;
              valid_q <= 1'b0;
              data_q  <= '0;
            end
          end else if (tmo_hit) begin
            state_q <= S_DONE;
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
            valid_q <= 1'b0;
            data_q  <= '0;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end

        S_WR: begin
          if (out_xfer) begin
            tcnt_q <= '0;
            if (cnt_q == 2'd3) begin
              state_q <= S_DONE;
              ack_q   <= 1'b1;
              valid_q <= 1'b0;
              data_q  <= '0;
              cnt_q   <= '0;
            end else begin
              cnt_q  <= cnt_inc;
              data_q <= wbyte_d;
            end
          end else if (tmo_hit) begin
            state_q <= S_DONE;
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end

        S_RD: begin
          if (in_cap) begin
            tcnt_q <= '0;
            cnt_q  <= cnt_inc;
            case (cnt_q)
              2'd0: shadow_q[7:0]   <= bus.ext_data_i;
              2'd1: shadow_q[15:8]  <= bus.ext_data_i;
              2'd2: shadow_q[23:16] <= bus.ext_data_i;
              default: begin
                // Last byte bypasses the shadow so rdata only ever changes on a complete word.
                rdata_q <= {bus.ext_data_i, shadow_q};
                state_q <= S_DONE;
                ack_q   <= 1'b1;
              end
            endcase
          end else if (tmo_hit) begin
            state_q <= S_DONE;
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
            cnt_q   <= '0;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          tcnt_q  <= '0;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          data_q  <= '0;
        end
      endcase
    end
  end

  assign bus.ack_o       = ack_q;
  assign bus.err_o       = err_q;
  assign bus.rdata_o     = rdata_q;
  assign bus.busy_o      = busy_q;
  assign bus.ext_data_o  = data_q;
  assign bus.ext_valid_o = valid_q;
  assign bus.dbg_state_o = state_q;

endmodule

// File: tb/tb_baby_ext_mem_bridge.sv
// Bench for baby_ext_mem_bridge: directed and randomised transactions checked against a
// beat-count/timing reference model built from the transfer rules.
module tb_baby_ext_mem_bridge;
  localparam int AW     = 5;
  localparam int TO     = 4;
  localparam int BUDGET = 200;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  baby_ext_mem_bridge_if #(.ADDR_W(AW)) bus ();
  baby_ext_mem_bridge #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic          t_we;
  logic [AW-1:0] t_addr;
  logic [31:0]   t_wdata;
  int            t_stall[5];
  logic [7:0]    t_rb[4];
  logic          n_we;
  logic [AW-1:0] n_addr;
  logic [31:0]   n_wdata;

  logic [7:0]    exp_q[$];
  logic [7:0]    obs_q[$];
  logic [7:0]    exp_beat[5];
  int            exp_cycles;
  logic          exp_err;
  logic [31:0]   model_rdata = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int rand_stall();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 12) return 0;
    if (r < 19) return int'($urandom_range(1, TO - 1));
    return int'($urandom_range(TO, TO + 2));
  endfunction

  // Reference: each beat costs its stall cycles plus one transfer edge; a beat that would wait
  // TO or more cycles ends the access TO edges after the previous beat, with err and no rdata.
  task automatic model_txn();
    int t;
    t = 0;
    exp_q.delete();
    exp_err = 1'b0;
    exp_beat[0] = {t_we, 2'b00, t_addr};
    for (int k = 1; k < 5; k++) exp_beat[k] = 8'((t_wdata >> (8 * (k - 1))) & 32'hFF);
    for (int b = 0; b < 5; b++) begin
      if (t_stall[b] >= TO) begin
        t += TO;
        exp_err = 1'b1;
        break;
      end
      t += t_stall[b] + 1;
      if (b == 0 || t_we) exp_q.push_back(exp_beat[b]);
    end
    exp_cycles = t + 1;
    if (!exp_err && !t_we) model_rdata = {t_rb[3], t_rb[2], t_rb[1], t_rb[0]};
  endtask

  // Called at a falling edge; returns at the falling edge of the idle cycle after ack.
  task automatic run_txn(input bit pre_req, input bit hold_next);
    int c;
    int b;
    int w;
    bit done;
    c = 0; b = 0; w = 0; done = 1'b0;
    model_txn();
    obs_q.delete();
    if (!pre_req) begin
      bus.req_i   = 1'b1;
      bus.we_i    = t_we;
      bus.addr_i  = t_addr;
      bus.wdata_i = t_wdata;
    end
    bus.ext_ready_i = 1'b0;
    bus.ext_valid_i = 1'b0;
    while (!done && c < BUDGET) begin
      @(negedge clk);
      c++;
      if (bus.ack_o === 1'b1) begin
        done = 1'b1;
        check("ack_cycle", c, exp_cycles);
        check("err_at_ack", bus.err_o, exp_err);
        check("rdata_at_ack", bus.rdata_o, model_rdata);
        check("beats_moved", obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
          check("byte_order", obs_q[i], exp_q[i]);
        bus.req_i = hold_next;
        if (hold_next) begin
          bus.we_i    = n_we;
          bus.addr_i  = n_addr;
          bus.wdata_i = n_wdata;
        end
        bus.ext_ready_i = 1'b0;
        bus.ext_valid_i = 1'b0;
      end else begin
        check("busy_in_txn", bus.busy_o, 1'b1);
        bus.req_i   = 1'($urandom_range(0, 1));
        bus.we_i    = 1'($urandom);
        bus.addr_i  = AW'($urandom);
        bus.wdata_i = $urandom;
        if (b == 0 || (t_we && b < 5)) begin
          check("valid_o_beat", bus.ext_valid_o, 1'b1);
          check("data_o_beat", bus.ext_data_o, exp_beat[b]);
          bus.ext_valid_i = 1'($urandom_range(0, 1));
          bus.ext_data_i  = 8'($urandom);
          bus.ext_ready_i = (w >= t_stall[b]);
          if (bus.ext_ready_i && bus.ext_valid_o) begin
            obs_q.push_back(bus.ext_data_o);
            b++;
            w = 0;
          end else begin
            w++;
          end
        end else if (b < 5) begin
          check("valid_o_read", bus.ext_valid_o, 1'b0);
          bus.ext_ready_i = 1'($urandom_range(0, 1));
          if (w >= t_stall[b]) begin
            bus.ext_valid_i = 1'b1;
            bus.ext_data_i  = t_rb[b-1];
            b++;
            w = 0;
          end else begin
            bus.ext_valid_i = 1'b0;
            bus.ext_data_i  = 8'($urandom);
            w++;
          end
        end else begin
          bus.ext_ready_i = 1'($urandom_range(0, 1));
          bus.ext_valid_i = 1'($urandom_range(0, 1));
          bus.ext_data_i  = 8'($urandom);
        end
      end
    end
    if (!done) begin
      check("ack_within_budget", c, exp_cycles);
      rst_n = 1'b0;
      bus.req_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_rdata = '0;
      bus.req_i = hold_next;
    end else begin
      @(negedge clk);
      check("ack_one_cycle", bus.ack_o, 1'b0);
      check("err_cleared", bus.err_o, 1'b0);
      check("busy_after", bus.busy_o, 1'b0);
      check("valid_after", bus.ext_valid_o, 1'b0);
      check("rdata_held", bus.rdata_o, model_rdata);
    end
  endtask

  task automatic rand_read_bytes();
    for (int k = 0; k < 4; k++) t_rb[k] = 8'($urandom);
  endtask

  initial begin
    bit pre;
    bit hold;
    bus.req_i       = 1'b0;
    bus.we_i        = 1'b0;
    bus.addr_i      = '0;
    bus.wdata_i     = '0;
    bus.ext_ready_i = 1'b0;
    bus.ext_data_i  = '0;
    bus.ext_valid_i = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ack", bus.ack_o, 1'b0);
    check("rst_err", bus.err_o, 1'b0);
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_rdata", bus.rdata_o, 32'h0);
    check("rst_data", bus.ext_data_o, 8'h00);
    check("rst_valid", bus.ext_valid_o, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain write, link always ready.
    t_we = 1'b1; t_addr = 5'h1A; t_wdata = 32'hDEADBEEF;
    t_stall = '{0, 0, 0, 0, 0};
    t_rb = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(1'b0, 1'b0);

    // Plain read, bytes arrive back to back.
    t_we = 1'b0; t_addr = 5'h03;
    t_rb = '{8'h78, 8'h56, 8'h34, 8'h12};
    run_txn(1'b0, 1'b0);

    // Write with three ready-low cycles on the third data byte.
    t_we = 1'b1; t_addr = AW'($urandom); t_wdata = $urandom;
    t_stall = '{0, 0, 0, 3, 0};
    run_txn(1'b0, 1'b0);

    // Read that never gets data: aborts with err, rdata keeps 12345678.
    t_we = 1'b0; t_addr = 5'h09;
    t_stall = '{0, 99, 0, 0, 0};
    rand_read_bytes();
    run_txn(1'b0, 1'b0);

    // Reset while the second data byte of a write is on the link.
    t_we = 1'b1; t_addr = 5'h0C; t_wdata = 32'hA5C30F1E;
    bus.req_i = 1'b1; bus.we_i = t_we; bus.addr_i = t_addr; bus.wdata_i = t_wdata;
    @(negedge clk);
    bus.req_i = 1'b0;
    bus.ext_ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_byte1", bus.ext_data_o, 8'h0F);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ack", bus.ack_o, 1'b0);
    check("mid_rst_err", bus.err_o, 1'b0);
    check("mid_rst_busy", bus.busy_o, 1'b0);
    check("mid_rst_rdata", bus.rdata_o, 32'h0);
    check("mid_rst_data", bus.ext_data_o, 8'h00);
    check("mid_rst_valid", bus.ext_valid_o, 1'b0);
    model_rdata = '0;
    @(negedge clk);
    bus.ext_ready_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", bus.busy_o, 1'b0);

    // Fresh read after reset, small stalls.
    t_we = 1'b0; t_addr = 5'h11;
    t_stall = '{1, 0, 2, 0, 1};
    rand_read_bytes();
    run_txn(1'b0, 1'b0);

    // Back to back: req held through ack, next header two cycles after ack.
    t_we = 1'b1; t_addr = 5'h07; t_wdata = $urandom;
    t_stall = '{0, 0, 0, 0, 0};
    n_we = 1'b0; n_addr = 5'h15; n_wdata = $urandom;
    run_txn(1'b0, 1'b1);
    t_we = n_we; t_addr = n_addr; t_wdata = n_wdata;
    rand_read_bytes();
    run_txn(1'b1, 1'b0);

    // Random traffic, including timeouts and chained requests.
    pre = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (pre) begin
        t_we = n_we; t_addr = n_addr; t_wdata = n_wdata;
      end else begin
        t_we = 1'($urandom); t_addr = AW'($urandom); t_wdata = $urandom;
      end
      for (int k = 0; k < 5; k++) t_stall[k] = rand_stall();
      rand_read_bytes();
      hold = (i < 39) && ($urandom_range(0, 3) == 0);
      if (hold) begin
        n_we = 1'($urandom); n_addr = AW'($urandom); n_wdata = $urandom;
      end
      run_txn(pre, hold);
      pre = hold;
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
